baud_gen: RTL

- Parametrised baud-rate tick generator for the UART TX/RX datapaths; successor to the single-count alarm timer.
- A fractional divider produces an oversample tick. A programmable oversample counter derives from it:
  - a bit tick (bit boundary), and
  - a mid-bit tick (RX sample point).
- A restart input re-phases everything to an RX start-bit edge.

---
 rtl/baud_gen.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/baud_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | baud_gen : fractional baud divider with oversample, bit and mid-bit ticks.  |
// | Optional BAUD_GEN_SHADOW_EN latches the config per bit.                      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module baud_gen #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4,
  parameter int OS_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              restart,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [OS_W-1:0]   os_ratio,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick
);

  localparam logic [DIV_W-1:0] c_div_one = 1;
  localparam logic [DIV_W:0]   c_per_one = 1;
  localparam logic [OS_W-1:0]  c_os_one  = 1;

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              mid_tick_q, mid_tick_d;

  logic [DIV_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic [OS_W-1:0]   cfg_os_ratio;

  logic [FRAC_W:0]   frac_sum;
  logic [DIV_W:0]    div_eff;
  logic [DIV_W:0]    period;
  logic [OS_W-1:0]   ratio_eff;
  logic [OS_W-1:0]   mid_pos;
  logic              terminal;
  logic              bit_end;
  logic              mid_hit;

`ifdef BAUD_GEN_SHADOW_EN
  logic [DIV_W-1:0]  div_int_q, div_int_d;
  logic [FRAC_W-1:0] div_frac_q, div_frac_d;
  logic [OS_W-1:0]   os_ratio_q, os_ratio_d;

  assign cfg_div_int  = div_int_q;
  assign cfg_div_frac = div_frac_q;
  assign cfg_os_ratio = os_ratio_q;

  // Config is re-sampled only at a bit boundary so a bit in flight keeps its timing.
  always_comb begin
    div_int_d  = div_int_q;
    div_frac_d = div_frac_q;
    os_ratio_d = os_ratio_q;
    if (restart || (enable && terminal && bit_end)) begin
      div_int_d  = div_int;
      div_frac_d = div_frac;
      os_ratio_d = os_ratio;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_int_q  <= div_int;
      div_frac_q <= div_frac;
      os_ratio_q <= os_ratio;
    end else begin
      div_int_q  <= div_int_d;
      div_frac_q <= div_frac_d;
      os_ratio_q <= os_ratio_d;
    end
  end
`else
  assign cfg_div_int  = div_int;
  assign cfg_div_frac = div_frac;
  assign cfg_os_ratio = os_ratio;
`endif

  // Period math is one bit wider than the divisor so div_int=all-ones plus carry fits.
  always_comb begin
    frac_sum  = {1'b0, frac_acc_q} + {1'b0, cfg_div_frac};
    div_eff   = (cfg_div_int > c_div_one) ? {1'b0, cfg_div_int} : c_per_one;
    period    = div_eff + {{DIV_W{1'b0}}, frac_sum[FRAC_W]};
    terminal  = ({1'b0, cnt_q} >= (period - c_per_one));
    ratio_eff = (cfg_os_ratio > c_os_one) ? cfg_os_ratio : c_os_one;
    mid_pos   = (ratio_eff >> 1) - c_os_one;
    bit_end   = (os_cnt_q >= (ratio_eff - c_os_one));
    mid_hit   = (ratio_eff == c_os_one) || (os_cnt_q == mid_pos);
  end

  always_comb begin
    cnt_d      = cnt_q;
    frac_acc_d = frac_acc_q;
    os_cnt_d   = os_cnt_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    if (restart) begin
      cnt_d      = '0;
      frac_acc_d = '0;
      os_cnt_d   = '0;
    end else if (enable) begin
      if (terminal) begin
        cnt_d      = '0;
        frac_acc_d = frac_sum[FRAC_W-1:0];
        os_tick_d  = 1'b1;
        bit_tick_d = bit_end;
        mid_tick_d = mid_hit;
        os_cnt_d   = bit_end ? '0 : (os_cnt_q + c_os_one);
      end else begin
        cnt_d = cnt_q + c_div_one;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      frac_acc_q <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      frac_acc_q <= frac_acc_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;

endmodule
`default_nettype wire
